// File: rtl/spi_rx_deser.sv
// SPI mode-0 slave receiver: oversampled pins, MSB-first word assembly, valid/ready holding register.
// Optional build macro SPI_RX_DC_EN adds a dc pin captured with the last bit of each word.
`timescale 1ns/1ps
module spi_rx_deser #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
`ifdef SPI_RX_DC_EN
  input  logic              dc,
  output logic              rx_dc,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_busy,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_p0;
  logic [SYNC_STAGES-1:0] cs_sync_p0;
  logic [SYNC_STAGES-1:0] mosi_sync_p0;
  logic                   sclk_d_p1;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise;

  state_t                 state_q, state_d;
  logic                   sample_en;
  logic [CNT_W-1:0]       cnt_p1;
  logic [DATA_W-1:0]      shift_p1;
  logic                   vld_p2;
  logic                   last_bit, consume, load;

  // Stage p0: pin synchronizers (idle values sclk=0, cs_n=1, mosi=0)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_p0 <= '0;
      cs_sync_p0   <= '1;
      mosi_sync_p0 <= '0;
    end else begin
      sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], sclk};
      cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], cs_n};
      mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
  assign cs_s      = cs_sync_p0[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_p0[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sclk_d_p1 <= 1'b0;
    else      sclk_d_p1 <= sclk_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_s) state_d = SHIFT;
      SHIFT:   if (cs_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A sample is refused on the cycle cs_n is seen high, even before the state leaves SHIFT
  always_comb begin
    rx_busy   = 1'b0;
    sample_en = 1'b0;
    if (state_q == SHIFT) begin
      rx_busy   = 1'b1;
      sample_en = sclk_rise & ~cs_s;
    end
  end

  assign last_bit = (cnt_p1 == CNT_W'(DATA_W - 1));

  // Stage p1: shift register and bit counter; p2 flags a completed word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p1   <= '0;
      shift_p1 <= '0;
      vld_p2   <= 1'b0;
    end else begin
      vld_p2 <= sample_en & last_bit;
      if (state_q != SHIFT || cs_s) begin
        cnt_p1 <= '0;
      end else if (sample_en) begin
        cnt_p1   <= last_bit ? '0 : cnt_p1 + CNT_W'(1);
        shift_p1 <= {shift_p1[DATA_W-2:0], mosi_s};
      end
    end
  end

  assign consume = rx_valid & rx_ready;
  assign load    = vld_p2 & (~rx_valid | rx_ready);

  // Stage p3: holding register with handshake and sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load) begin
        rx_data  <= shift_p1;
        rx_valid <= 1'b1;
      end else if (consume) begin
        rx_valid <= 1'b0;
      end
      if (vld_p2 && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (ovr_clr)                    overrun <= 1'b0;
    end
  end

`ifdef SPI_RX_DC_EN
  logic [SYNC_STAGES-1:0] dc_sync_p0;
  logic                   dc_word_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dc_sync_p0 <= '0;
      dc_word_p2 <= 1'b0;
      rx_dc      <= 1'b0;
    end else begin
      dc_sync_p0 <= {dc_sync_p0[SYNC_STAGES-2:0], dc};
      if (sample_en && last_bit) dc_word_p2 <= dc_sync_p0[SYNC_STAGES-1];
      if (load)                  rx_dc      <= dc_word_p2;
    end
  end
`endif

endmodule

// File: tb/tb_spi_rx_deser.sv
// Bench for spi_rx_deser: table of single-byte frames plus hand sequences for overrun,
// aborted frames, same-cycle consume/load and the optional dc bit; scoreboard queue of words.
`timescale 1ns/1ps
module tb_spi_rx_deser;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sclk = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              rx_ready = 1'b0;
  logic              ovr_clr = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_busy, overrun;
`ifdef SPI_RX_DC_EN
  logic              dc_pin = 1'b0;
  logic              rx_dc;
`endif

  typedef struct { logic [7:0] word; logic dc; } exp_t;
  typedef struct { logic [7:0] word; logic dc; logic [7:0] exp_data; logic exp_dc; } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  spi_rx_deser #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
`ifdef SPI_RX_DC_EN
    .dc(dc_pin), .rx_dc(rx_dc),
`endif
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_busy(rx_busy), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: look at the handshake on the falling edge, then return on the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", rx_data, e.word);
`ifdef SPI_RX_DC_EN
        check("rx_dc", rx_dc, e.dc);
`endif
      end
    end
    @(posedge clk);
  endtask

  // Sends n bits MSB-first; returns 2ns after the rising edge on which the last sclk rise was driven.
  task automatic spi_bits(input logic [7:0] b, input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      step(); #2;
      sclk = 1'b0;
      mosi = b[7-i];
`ifdef SPI_RX_DC_EN
      dc_pin = d;
`else
      if (d) mosi = b[7-i];
`endif
      repeat (4) step();
      #2 sclk = 1'b1;
      if (i != n - 1) repeat (3) step();
    end
  endtask

  task automatic cs_low();
    step(); #2 cs_n = 1'b0;
    repeat (4) step();
    #1 check("busy_on", rx_busy, 1'b1);
  endtask

  task automatic cs_high();
    step(); #2 sclk = 1'b0;
    repeat (4) step();
    #2 cs_n = 1'b1;
    repeat (5) step();
    #1 check("busy_off", rx_busy, 1'b0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 8'h5A, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 8'h80, 1'b0};

    // Reset with random pin activity
    for (int i = 0; i < 6; i++) begin
      sclk = 1'($urandom_range(0, 1));
      cs_n = 1'($urandom_range(0, 1));
      mosi = 1'($urandom_range(0, 1));
      rx_ready = 1'($urandom_range(0, 1));
      step(); #1;
    end
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_busy", rx_busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
`ifdef SPI_RX_DC_EN
    check("rst_rx_dc", rx_dc, 1'b0);
`endif
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; rx_ready = 1'b0;
    step(); #2 rst = 1'b1;
    repeat (4) step();

    // Table of single-byte frames, consumer always ready
    rx_ready = 1'b1;
    foreach (vecs[i]) begin
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_dc});
      cs_low();
      spi_bits(vecs[i].word, 8, vecs[i].dc);
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
        step(); #1;
        if (rx_valid) begin
          lat = c;
          break;
        end
      end
      check("latency", lat, LAT);
      check("no_overrun", overrun, 1'b0);
      step(); #1;
      check("valid_one_cycle", rx_valid, 1'b0);
      cs_high();
    end

    // Back-to-back 0x3C, 0xC3 with no consumer: second word dropped, overrun set
    rx_ready = 1'b0;
    exp_q.push_back('{8'h3C, 1'b0});
    cs_low();
    spi_bits(8'h3C, 8, 1'b0);
    spi_bits(8'hC3, 8, 1'b0);
    repeat (3) step();
    #2 ovr_clr = 1'b1;
    step(); #1;
    check("ovr_set_wins", overrun, 1'b1);
    #1 ovr_clr = 1'b0;
    check("ovr_hold_data", rx_data, 8'h3C);
    check("ovr_hold_valid", rx_valid, 1'b1);
    cs_high();
    step(); #2 ovr_clr = 1'b1;
    step(); #2 ovr_clr = 1'b0;
    check("ovr_clr", overrun, 1'b0);
    rx_ready = 1'b1;
    step(); #2 rx_ready = 1'b0;
    step(); #1;
    check("ovr_drained", rx_valid, 1'b0);

    // sclk toggling with cs_n high must not produce a word
    rx_ready = 1'b1;
    spi_bits(8'hFF, 8, 1'b0);
    repeat (6) step();
    #1 check("idle_sclk_ignored", rx_valid, 1'b0);
    #1 sclk = 1'b0;

    // Frame aborted after 5 bits, then a full 0x81
    cs_low();
    spi_bits(8'hF8, 5, 1'b0);
    cs_high();
    exp_q.push_back('{8'h81, 1'b0});
    cs_low();
    spi_bits(8'h81, 8, 1'b0);
    repeat (8) step();
    cs_high();
    check("partial_dropped", exp_q.size(), 0);
    check("partial_no_ovr", overrun, 1'b0);

    // Consumer takes 0x11 on the very cycle 0x22 completes
    rx_ready = 1'b0;
    exp_q.push_back('{8'h11, 1'b0});
    exp_q.push_back('{8'h22, 1'b0});
    cs_low();
    spi_bits(8'h11, 8, 1'b0);
    spi_bits(8'h22, 8, 1'b0);
    repeat (3) step();
    #2 rx_ready = 1'b1;
    step(); #1;
    check("swap_valid", rx_valid, 1'b1);
    check("swap_data", rx_data, 8'h22);
    check("swap_no_ovr", overrun, 1'b0);
    #1 rx_ready = 1'b0;
    cs_high();
    #2 rx_ready = 1'b1;
    step(); #2 rx_ready = 1'b0;
    step(); #1;
    check("swap_drained", rx_valid, 1'b0);

`ifdef SPI_RX_DC_EN
    // Command byte then data byte
    rx_ready = 1'b1;
    exp_q.push_back('{8'h2A, 1'b0});
    exp_q.push_back('{8'h55, 1'b1});
    cs_low();
    spi_bits(8'h2A, 8, 1'b0);
    spi_bits(8'h55, 8, 1'b1);
    repeat (8) step();
    cs_high();
`endif

    repeat (4) step();
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
